ps2_rx_queue: RTL and testbench
===============================

Name: ps2_rx_queue

Overview:
- Parametrised PS/2 keyboard receiver that runs entirely in the `clk` domain.
- Oversamples and filters `ps2_clk`/`ps2_data`, deframes 11-bit frames and checks parity, stop bit and inter-bit timeout.
- Decodes E0 (extended) and F0 (release) prefixes into tagged key events and buffers them in a FIFO with a valid/ready interface.
- Also keeps a shifting history of recent make codes for the hex display path.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before filtered `ps2_clk` changes level (>=1).
- TIMEOUT_CYCLES, 50000: `clk` cycles without a strobe, mid-frame, before the frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; power of two, >=2.
- HIST_BYTES, 2: number of make-code bytes held on `code`.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts head event when `ev_valid` & `ev_ready`.
- ev_code  out  8  scan code of head event.
- ev_ext  out  1  head event was E0-prefixed.
- ev_rel  out  1  head event was F0-prefixed (break).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- code  out  8*HIST_BYTES  make-code history; newest byte in [7:0].
- err_parity  out  1  one-cycle pulse on a parity error.
- err_frame  out  1  one-cycle pulse when the stop bit is 0.
- err_timeout  out  1  one-cycle pulse on a frame timeout.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- ovf_clr  in  1  clears `overflow`; a same-cycle set wins.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, prefix flags cleared, filtered clock = 1, filter counters 0, timeout counter 0.
- Input path:
  - 2-flop synchroniser on each input.
  - Filtered `ps2_clk` takes a new level after FILTER_LEN consecutive equal synchronised samples that differ from the current filtered level.
  - A strobe is generated in the cycle the filtered clock goes 1->0.
  - Data is sampled from synchronised `ps2_data` in the strobe cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: strobe with data 0 -> DATA, bit index 0. Strobe with data 1 -> stay in IDLE, no error.
  - DATA: store bit LSB-first at the bit index; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: always -> IDLE.
    - Data 0 -> `err_frame`.
    - Else if XOR of the 8 data bits and the parity bit is 0 -> `err_parity`.
    - Else the byte is valid.
    - If the stop bit is 0 and parity is also bad, only `err_frame` pulses.
  - Timeout: in any state other than IDLE, the counter resets on each strobe. On reaching TIMEOUT_CYCLES with no strobe -> IDLE, `err_timeout` pulse, partial byte discarded.
- Decoder on a valid byte:
  - E0 -> set ext flag.
  - F0 -> set rel flag.
  - Any other byte -> push event {code, ext, rel}, then clear both flags.
  - Any error pulse clears both flags.
- History: on a pushed event with rel=0, `code` <= {code[8*HIST_BYTES-9:0], byte}. Release events and prefixes do not change `code`. The history update is independent of FIFO fullness.
- Latency: `ev_valid` and the head fields are valid 2 `clk` cycles after the stop-bit strobe cycle when the FIFO was empty. `code` updates 1 cycle after the stop-bit strobe. Error pulses assert 1 cycle after the offending strobe or timeout.
- FIFO:
  - First-word fall-through; head fields are stable while `ev_valid`=1 and `ev_ready`=0.
  - Pop when `ev_valid` & `ev_ready`. Read and write pointers wrap modulo FIFO_DEPTH.
  - Push while full without a pop in the same cycle: event dropped, `overflow` set.
  - Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
  - `ev_*` fields are don't-care while `ev_valid`=0.
- Reset mid-frame: the frame is discarded, no error pulse, and the next clean frame decodes normally.

Test Plan:
- Frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> one event ev_code=1C, ext=0, rel=0; `code`=16'h001C; no error pulses.
- Frames F0, 1C, then E0, 75 -> events {1C, rel=1} then {75, ext=1}; `code` goes 001C -> 001C -> 1C75.
- 0x1C with parity bit 1 -> `err_parity` single pulse, no event. Then E0 followed by a frame with stop=0 -> `err_frame`, ext cleared. Next clean 0x1C -> event with ext=0.
- FIFO_DEPTH=8, `ev_ready`=0, nine make frames 0x01..0x09:
  - `fifo_count`=8, `overflow`=1, `code` ends 0x0809.
  - Popping returns 01..08 in order.
  - `ovf_clr` -> `overflow`=0.
- Start bit plus 3 data bits, then idle > TIMEOUT_CYCLES -> `err_timeout` pulse and return to IDLE; following 0x1C decodes correctly.
- FILTER_LEN=8, 3-cycle low glitch on `ps2_clk` -> no strobe. Assert `rst` after the 5th data bit of a frame -> all outputs 0 and no event; next clean frame decodes.

Source files
------------

// File: rtl/ps2_rx_queue_if.sv
// Key-event stream between the PS/2 receiver and its consumer.
// The receiver drives the master side; the consumer owns ev_ready.
interface ps2_rx_queue_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_rel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_rel,
        output ev_ready
    );
endinterface

// File: rtl/ps2_rx_queue.sv
// PS/2 keyboard receiver: filter, deframe, E0/F0 decode, event FIFO
// and a make-code history, all in the clk domain.
module ps2_rx_queue #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int HIST_BYTES     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    ps2_rx_queue_if.master                ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [8*HIST_BYTES-1:0]       code,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int HW  = 8 * HIST_BYTES;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           strobe_q;

    logic [1:0]     state_q, state_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ext_q, ext_d, rel_q, rel_d;
    logic           push_q, push_d;
    logic [9:0]     pdata_q, pdata_d;
    logic [HW-1:0]  code_q, code_d;
    logic           ep_q, ep_d, ef_q, ef_d, et_q, et_d;

    logic [9:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           full, pop, wr_en;
    logic [9:0]     head;

    // Level changes only after FILTER_LEN agreeing samples in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1))
                filt_d = ~filt_q;
            else
                fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        par_d   = par_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        push_d  = 1'b0;
        pdata_d = pdata_q;
        code_d  = code_q;
        ep_d    = 1'b0;
        ef_d    = 1'b0;
        et_d    = 1'b0;
        if (state_q == S_IDLE || strobe_q)
            tmo_d = '0;
        else
            tmo_d = tmo_q + 1'b1;

        if (state_q != S_IDLE && !strobe_q &&
            tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            et_d    = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end else if (strobe_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = S_DATA;
                        bidx_d  = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d[bidx_q] = dat_s2_q;
                    bidx_d = bidx_q + 3'd1;
                    if (bidx_q == 3'd7)
                        state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s2_q || !(^{shift_q, par_q})) begin
                        ef_d  = ~dat_s2_q;
                        ep_d  = dat_s2_q;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        rel_d = 1'b1;
                    end else begin
                        push_d  = 1'b1;
                        pdata_d = {shift_q, ext_q, rel_q};
                        ext_d   = 1'b0;
                        rel_d   = 1'b0;
                        if (!rel_q) begin
                            code_d       = code_q << 8;
                            code_d[7:0]  = shift_q;
                        end
                    end
                end
            endcase
        end
    end

    // FIFO: a full push survives only when a pop frees the slot.
    always_comb begin
        full  = cnt_q == CW'(FIFO_DEPTH);
        pop   = ev.ev_valid & ev.ev_ready;
        wr_en = push_q & (~full | pop);
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        if (wr_en && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop)
            cnt_d = cnt_q - 1'b1;
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (push_q && full && !pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            strobe_q <= 1'b0;
            state_q  <= S_IDLE;
            bidx_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            push_q   <= 1'b0;
            pdata_q  <= '0;
            code_q   <= '0;
            ep_q     <= 1'b0;
            ef_q     <= 1'b0;
            et_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            strobe_q <= filt_q & ~filt_d;
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            push_q   <= push_d;
            pdata_q  <= pdata_d;
            code_q   <= code_d;
            ep_q     <= ep_d;
            ef_q     <= ef_d;
            et_q     <= et_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_q] <= pdata_q;
    end

    assign head        = mem_q[rd_q];
    assign ev.ev_valid = cnt_q != '0;
    assign ev.ev_code  = ev.ev_valid ? head[9:2] : 8'h00;
    assign ev.ev_ext   = ev.ev_valid & head[1];
    assign ev.ev_rel   = ev.ev_valid & head[0];
    assign fifo_count  = cnt_q;
    assign code        = code_q;
    assign err_parity  = ep_q;
    assign err_frame   = ef_q;
    assign err_timeout = et_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_rx_queue.sv
// Directed bench for ps2_rx_queue: frame table plus FIFO, timeout,
// glitch and mid-frame reset sequences.
module tb_ps2_rx_queue;
    localparam int TMO = 1000;
    localparam int HP  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ovf_clr = 1'b0;
    logic [3:0]  fifo_count;
    logic [15:0] code;
    logic        err_parity, err_frame, err_timeout, overflow;
    int          n_par = 0, n_frm = 0, n_tmo = 0;
    int          total = 0, bad = 0;

    ps2_rx_queue_if evif ();

    ps2_rx_queue #(
        .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH(8), .HIST_BYTES(2)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev(evif.master), .fifo_count(fifo_count), .code(code),
        .err_parity(err_parity), .err_frame(err_frame),
        .err_timeout(err_timeout), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_parity)  n_par <= n_par + 1;
        if (err_frame)   n_frm <= n_frm + 1;
        if (err_timeout) n_tmo <= n_tmo + 1;
    end

    typedef struct {
        logic [7:0]  b;
        logic        bad_par;
        logic        stop;
        logic        e_ev;
        logic [7:0]  e_code;
        logic        e_ext;
        logic        e_rel;
        logic [15:0] e_hist;
        int          e_par;
        int          e_frm;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic stop);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bits({stop, p, b, 1'b0}, 11);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    task automatic pop1();
        evif.ev_ready = 1'b1;
        wait_cyc(1);
        evif.ev_ready = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_valid"}, 32'(evif.ev_valid), 32'd0);
        chk({nm, "_cnt"}, 32'(fifo_count), 32'd0);
        chk({nm, "_code"}, 32'(code), 32'd0);
        chk({nm, "_ovf"}, 32'(overflow), 32'd0);
        chk({nm, "_errs"}, 32'({err_parity, err_frame, err_timeout}), 32'd0);
        chk({nm, "_evcode"}, 32'({evif.ev_code, evif.ev_ext, evif.ev_rel}),
            32'd0);
    endtask

    task automatic expect_one(input string nm, input logic [7:0] c,
                              input logic x, input logic r);
        chk({nm, "_valid"}, 32'(evif.ev_valid), 32'd1);
        chk({nm, "_head"}, 32'({evif.ev_code, evif.ev_ext, evif.ev_rel}),
            32'({c, x, r}));
        pop1();
        chk({nm, "_empty"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        int p0, f0, t0;
        evif.ev_ready = 1'b0;

        vecs[0]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 16'h001C, 0, 0};
        vecs[1]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 16'h001C, 0, 0};
        vecs[2]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 1, 16'h001C, 0, 0};
        vecs[3]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 16'h001C, 0, 0};
        vecs[4]  = '{8'h75, 0, 1, 1, 8'h75, 1, 0, 16'h1C75, 0, 0};
        vecs[5]  = '{8'h1C, 1, 1, 0, 8'h00, 0, 0, 16'h1C75, 1, 0};
        vecs[6]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 16'h1C75, 0, 0};
        vecs[7]  = '{8'h1C, 0, 0, 0, 8'h00, 0, 0, 16'h1C75, 0, 1};
        vecs[8]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 16'h751C, 0, 0};
        vecs[9]  = '{8'h22, 1, 0, 0, 8'h00, 0, 0, 16'h751C, 0, 1};
        vecs[10] = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 16'h751C, 0, 0};
        vecs[11] = '{8'h22, 0, 1, 1, 8'h22, 0, 1, 16'h751C, 0, 0};
        vecs[12] = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 16'h751C, 0, 0};
        vecs[13] = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 16'h751C, 0, 0};
        vecs[14] = '{8'h5A, 0, 1, 1, 8'h5A, 1, 1, 16'h751C, 0, 0};
        vecs[15] = '{8'h12, 0, 1, 1, 8'h12, 0, 0, 16'h1C12, 0, 0};

        wait_cyc(3);
        chk_idle_outputs("rst");
        rst = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < 16; i++) begin
            p0 = n_par; f0 = n_frm; t0 = n_tmo;
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop);
            chk($sformatf("v%0d_code", i), 32'(code), 32'(vecs[i].e_hist));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(vecs[i].e_ev));
            chk($sformatf("v%0d_par", i), 32'(n_par - p0), 32'(vecs[i].e_par));
            chk($sformatf("v%0d_frm", i), 32'(n_frm - f0), 32'(vecs[i].e_frm));
            chk($sformatf("v%0d_tmo", i), 32'(n_tmo - t0), 32'd0);
            if (vecs[i].e_ev)
                expect_one($sformatf("v%0d", i), vecs[i].e_code,
                           vecs[i].e_ext, vecs[i].e_rel);
        end

        // Overflow: nine makes into an eight-deep FIFO.
        do_reset();
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 1'b0, 1'b1);
        chk("ovf_cnt", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_code", 32'(code), 32'h0809);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_pop%0d", i),
                32'({evif.ev_valid, evif.ev_code}), 32'({1'b1, 8'(i)}));
            pop1();
        end
        chk("ovf_drained", 32'({evif.ev_valid, fifo_count}), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Timeout after start plus three data bits.
        p0 = n_par; f0 = n_frm; t0 = n_tmo;
        send_bits(11'b000_0000_1010, 4);
        ps2_data = 1'b1;
        wait_cyc(TMO + 100);
        chk("tmo_pulse", 32'(n_tmo - t0), 32'd1);
        chk("tmo_noev", 32'(fifo_count), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("tmo_errs", 32'((n_par - p0) + (n_frm - f0)), 32'd0);
        expect_one("tmo_next", 8'h1C, 1'b0, 1'b0);

        // A 3-cycle clock glitch with data low must not start a frame.
        p0 = n_par; f0 = n_frm; t0 = n_tmo;
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(5);
        ps2_data = 1'b1;
        wait_cyc(30);
        send_frame(8'h33, 1'b0, 1'b1);
        chk("glitch_errs", 32'((n_par - p0) + (n_frm - f0) + (n_tmo - t0)),
            32'd0);
        chk("glitch_code", 32'(code), 32'h1C33);
        expect_one("glitch_ev", 8'h33, 1'b0, 1'b0);

        // Reset after the fifth data bit.
        send_bits({2'b11, 8'h1C, 1'b0}, 6);
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        p0 = n_par; f0 = n_frm; t0 = n_tmo;
        wait_cyc(5);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("midrst_errs", 32'((n_par - p0) + (n_frm - f0) + (n_tmo - t0)),
            32'd0);
        chk("midrst_code", 32'(code), 32'h001C);
        expect_one("midrst_ev", 8'h1C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
